edu_input_conditioner: RTL
==========================

# edu_input_conditioner

Input front end for the edugraphics board design: synchronises the eight slide switches and the push buttons into `clk`, debounces every bit, and produces the clean `switch`/`push_btn` levels consumed by `edugraphics_test`. It also produces single-cycle press/release/change strobes so downstream logic never edge-detects raw pins. It sits between the board pins and the graphics test block, one instance per design.

## Interface

- SW_W, 8, number of slide switch inputs
- BTN_W, 4, number of push button inputs
- TICK_DIV, 50000, clk cycles per debounce sample tick (1 ms at 50 MHz); legal ≥ 1
- STABLE_TICKS, 10, consecutive differing samples needed to accept a new level; legal ≥ 1

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- switch_raw  in  SW_W  switch pins, asynchronous to clk
- push_btn_raw  in  BTN_W  button pins, asynchronous to clk, 1 = pressed
- switch  out  SW_W  debounced switch levels
- push_btn  out  BTN_W  debounced button levels
- btn_press  out  BTN_W  one-cycle pulse per bit on debounced 0→1
- btn_release  out  BTN_W  one-cycle pulse per bit on debounced 1→0
- sw_changed  out  1  one-cycle pulse when any debounced switch bit changes
- tick  out  1  one-cycle sample strobe (debug/observability)

## Operation

- Reset (async assert, sync-free release): synchronisers, prescaler, all debounce counters, all outputs = 0.
- Synchroniser: two flops per raw bit, reset to 0; debouncer sees only the second flop (`s`).
- Prescaler: counts 0..TICK_DIV-1, wraps to 0; `tick` = 1 in the cycle count == TICK_DIV-1. TICK_DIV = 1 → tick every cycle.
- Per-bit debouncer, state `q` (the output level) and counter `c`, width clog2(STABLE_TICKS)+1, updated only on tick:
  - s == q → c ← 0.
  - s != q and c == STABLE_TICKS-1 → q ← s, c ← 0.
  - s != q otherwise → c ← c+1.
- A single equal sample between differing samples clears the count (glitch rejection); counts never carry across a reversal.
- Strobes are registered together with `q`: in the cycle `push_btn[i]` first shows 1, `btn_press[i]` = 1; first shows 0, `btn_release[i]` = 1. Never both for one bit in one cycle.
- `sw_changed` = 1 in the cycle the `switch` bus differs from its previous value; several bits accepted on the same tick → one pulse.
- Bits are fully independent; simultaneous acceptance on different bits is legal and produces per-bit strobes in the same cycle.
- After reset release with an input already high, the bit debounces normally and emits `btn_press`/`sw_changed` once accepted (intended; downstream treats it as a real press).

## Timing

- All outputs registered; no combinational path from raw inputs to outputs.
- Clean raw step held steady: output changes after 2 synchroniser cycles plus between (STABLE_TICKS-1)·TICK_DIV+1 and STABLE_TICKS·TICK_DIV cycles, i.e. on the STABLE_TICKS-th tick sampling the new `s`.
- Strobes are exactly one clk wide, even when TICK_DIV = 1.
- Reset asserted mid-count: all state cleared same instant, no strobe emitted on or after release until a new acceptance.

## Test plan

(TICK_DIV = 4, STABLE_TICKS = 3, BTN_W = 4 unless stated)

- Reset: hold rst 5 cycles with raw inputs 0 → all outputs 0; after release `tick` pulses at cycles 4, 8, 12 (period 4, width 1).
- Clean switch: switch_raw = 8'h01 held → switch = 8'h01 within 2+12 cycles, on the 3rd tick seeing s[0]=1; sw_changed exactly one pulse in that cycle.
- Bounce: push_btn_raw[1] = 1 for one tick, 0 for one tick, then 1 held → push_btn[1] rises only after 3 consecutive ticks of 1; exactly one btn_press[1], no btn_release.
- Release and simultaneity: from push_btn = 4'b0010, raw → 0 held → single btn_release[1], no btn_press; switch_raw 8'h00→8'hA5 in one cycle → switch jumps to 8'hA5 in one cycle, single sw_changed.
- Reset mid-operation: raw button 1 held, rst pulsed when counter = 2 → outputs 0 immediately, no strobes; after release a full 3 ticks pass before push_btn = 1 with one btn_press.
- Degenerate: TICK_DIV = 1, STABLE_TICKS = 1 → raw step appears on output 3 cycles later, strobe width 1 cycle.

Source files
------------

// File: rtl/edu_input_conditioner.sv
// edu_input_conditioner: synchronise, debounce and edge-strobe board switches and push buttons
module edu_input_conditioner #(
  parameter int SW_W = 8,
  parameter int BTN_W = 4,
  parameter int TICK_DIV = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW_W-1:0]  switch_raw,
  input  logic [BTN_W-1:0] push_btn_raw,
  output logic [SW_W-1:0]  switch,
  output logic [BTN_W-1:0] push_btn,
  output logic [BTN_W-1:0] btn_press,
  output logic [BTN_W-1:0] btn_release,
  output logic             sw_changed,
  output logic             tick
);
  localparam int N = SW_W + BTN_W;
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS) + 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] C_LAST = CW'(STABLE_TICKS - 1);
  logic [N-1:0] s1, s, q, q_n;
  logic [PW-1:0] cnt, cnt_n;
  logic [CW-1:0] c [N];
  logic [CW-1:0] c_n [N];
  always_comb begin
    cnt_n = cnt == P_LAST ? '0 : cnt + PW'(1);
    q_n = q;
    for (int i = 0; i < N; i++) begin
      q_n[i] = tick && s[i] != q[i] && c[i] == C_LAST ? s[i] : q[i];
      c_n[i] = !tick ? c[i] : (s[i] == q[i] || c[i] == C_LAST) ? '0 : c[i] + CW'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s <= '0;
      q <= '0;
      c <= '{default: '0};
      cnt <= '0;
      tick <= 1'b0;
      btn_press <= '0;
      btn_release <= '0;
      sw_changed <= 1'b0;
    end else begin
      s1 <= {push_btn_raw, switch_raw};
      s <= s1;
      q <= q_n;
      c <= c_n;
      cnt <= cnt_n;
      tick <= cnt_n == P_LAST;
      btn_press <= q_n[N-1:SW_W] & ~q[N-1:SW_W];
      btn_release <= ~q_n[N-1:SW_W] & q[N-1:SW_W];
      sw_changed <= |(q_n[SW_W-1:0] ^ q[SW_W-1:0]);
    end
  end
  assign switch = q[SW_W-1:0];
  assign push_btn = q[N-1:SW_W];
endmodule
